// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M/RV64M multiply-divide unit with pipeline stall and flush handling.
module ex_muldiv #(
  parameter int XLEN = 32,
  parameter int MUL_LATENCY = 2,
  parameter int DIV_BITS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            annul_i,
  output logic [XLEN-1:0] result_o,
  output logic            ready_o,
  output logic            busy_o,
  output logic            stallreq_o
);
  localparam int ITER = XLEN / DIV_BITS;
  localparam int CW = $clog2(ITER) + 1;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_n;
  logic [1:0]        op_r;
  logic [XLEN-1:0]   a_r, b_r, rem_r, quo_r, b_mag, mul_res, div_res, special_res;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] ma, mb, prod;
  logic [XLEN:0]     r;
  logic [XLEN-1:0]   q;
  logic              special, mul_last, div_last, neg_q, neg_r;
  assign busy_o = state != IDLE;
  assign stallreq_o = (state == IDLE && start_i && !annul_i) || state == MUL || state == DIV;
  assign mul_last = cnt == CW'(MUL_LATENCY - 1);
  assign div_last = cnt == CW'(ITER - 1);
  assign special = op_i[2] && (rs2_i == '0 ||
                   (!op_i[0] && rs1_i == {1'b1, {(XLEN-1){1'b0}}} && rs2_i == '1));
  assign special_res = rs2_i == '0 ? (op_i[1] ? rs1_i : '1) : (op_i[1] ? '0 : rs1_i);
  // Only rs1 stays signed for MULHSU; MULHU zero-extends both operands
  assign ma = {{XLEN{op_r != 2'd3 && a_r[XLEN-1]}}, a_r};
  assign mb = {{XLEN{!op_r[1] && b_r[XLEN-1]}}, b_r};
  assign prod = ma * mb;
  assign mul_res = op_r == 2'd0 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  assign b_mag = (!op_r[0] && b_r[XLEN-1]) ? -b_r : b_r;
  assign neg_q = !op_r[0] && (a_r[XLEN-1] ^ b_r[XLEN-1]);
  assign neg_r = !op_r[0] && a_r[XLEN-1];
  assign div_res = op_r[1] ? (neg_r ? -r[XLEN-1:0] : r[XLEN-1:0]) : (neg_q ? -q : q);
  always_comb begin
    r = {1'b0, rem_r};
    q = quo_r;
    for (int k = 0; k < DIV_BITS; k++) begin
      r = {r[XLEN-1:0], q[XLEN-1]};
      q = {q[XLEN-2:0], 1'b0};
      if (r >= {1'b0, b_mag}) begin
        r = r - {1'b0, b_mag};
        q[0] = 1'b1;
      end
    end
  end
  always_comb begin
    state_n = state;
    if (annul_i) state_n = IDLE;
    else case (state)
      IDLE: if (start_i) state_n = !op_i[2] ? MUL : special ? DONE : DIV;
      MUL: if (mul_last) state_n = DONE;
      DIV: if (div_last) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r <= '0;
      a_r <= '0;
      b_r <= '0;
      rem_r <= '0;
      quo_r <= '0;
      cnt <= '0;
      result_o <= '0;
      ready_o <= 1'b0;
    end else begin
      ready_o <= 1'b0;
      if (!annul_i) case (state)
        IDLE: if (start_i) begin
          op_r <= op_i[1:0];
          a_r <= rs1_i;
          b_r <= rs2_i;
          cnt <= '0;
          rem_r <= '0;
          quo_r <= (op_i[2] && !op_i[0] && rs1_i[XLEN-1]) ? -rs1_i : rs1_i;
          if (special) begin
            result_o <= special_res;
            ready_o <= 1'b1;
          end
        end
        MUL: begin
          cnt <= cnt + 1'b1;
          if (mul_last) begin
            result_o <= mul_res;
            ready_o <= 1'b1;
          end
        end
        DIV: begin
          cnt <= cnt + 1'b1;
          rem_r <= r[XLEN-1:0];
          quo_r <= q;
          if (div_last) begin
            result_o <= div_res;
            ready_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed checks of ex_muldiv, default and wide configurations.
module tb_ex_muldiv;
  logic        clk = 1'b0, rst = 1'b1;
  logic        start = 1'b0, annul = 1'b0;
  logic [2:0]  op_i = '0;
  logic [31:0] rs1 = '0, rs2 = '0, result, prev;
  logic        ready, busy, stallreq;
  logic        w_start = 1'b0;
  logic [2:0]  w_op = '0;
  logic [63:0] w_rs1 = '0, w_rs2 = '0, w_result;
  logic        w_ready, w_busy, w_stallreq;
  int          checks = 0, fails = 0, pulses, n;

  always #5 clk = ~clk;

  ex_muldiv dut (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op_i), .rs1_i(rs1), .rs2_i(rs2),
    .annul_i(annul), .result_o(result), .ready_o(ready), .busy_o(busy), .stallreq_o(stallreq)
  );

  ex_muldiv #(.XLEN(64), .MUL_LATENCY(2), .DIV_BITS(2)) wide (
    .clk(clk), .rst(rst), .start_i(w_start), .op_i(w_op), .rs1_i(w_rs1), .rs2_i(w_rs2),
    .annul_i(1'b0), .result_o(w_result), .ready_o(w_ready), .busy_o(w_busy), .stallreq_o(w_stallreq)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue at the current negedge (cycle N); optionally toggles start with junk while busy.
  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a, b, exp,
                     input int lat, input bit noise);
    int k, bad;
    k = 0;
    bad = 0;
    start = 1'b1; op_i = op; rs1 = a; rs2 = b;
    #1 chk({tag, "_stall_n"}, 64'(stallreq), 64'd1);
    do begin
      @(negedge clk);
      k++;
      if (!ready && !stallreq) bad++;
      start = noise && !ready && k[0];
      if (noise) begin op_i = 3'd5; rs1 = 32'h1234; rs2 = 32'h0; end
    end while (!ready && k < 100);
    start = 1'b0;
    chk({tag, "_lat"}, 64'(k), 64'(lat));
    chk({tag, "_res"}, {32'h0, result}, {32'h0, exp});
    chk({tag, "_stall"}, 64'(bad) + 64'(stallreq), 64'd0);
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(ready), 64'd0);
  endtask

  initial begin
    #1;
    chk("rst_result", {32'h0, result}, 64'd0);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_stall", 64'(stallreq), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run("mul", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 3, 1'b0);
    run("mulh", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 3, 1'b0);
    run("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 3, 1'b0);
    run("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 3, 1'b0);
    run("div", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 1'b0);
    run("rem", 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, 1'b0);
    run("divu", 3'd5, 32'd100, 32'd7, 32'd14, 33, 1'b0);
    run("remu", 3'd7, 32'd100, 32'd7, 32'd2, 33, 1'b0);
    run("divu_z", 3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 1'b0);
    run("remu_z", 3'd7, 32'd5, 32'd0, 32'd5, 1, 1'b0);
    run("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1'b0);
    run("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, 1'b0);
    run("mul_busy", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 3, 1'b1);
    run("div_busy", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 1'b1);
    // flush a DIV at N+10, then start a MUL at N+11
    prev = result;
    pulses = 0;
    start = 1'b1; op_i = 3'd4; rs1 = 32'd100; rs2 = 32'd7;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (ready) pulses++;
    end
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    chk("flush_pulse", 64'(pulses) + 64'(ready), 64'd0);
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_stall", 64'(stallreq), 64'd0);
    chk("flush_result", {32'h0, result}, {32'h0, prev});
    run("mul_after_flush", 3'd0, 32'd3, 32'd5, 32'd15, 3, 1'b0);
    // asynchronous reset between edges mid-DIV
    start = 1'b1; op_i = 3'd4; rs1 = 32'hFFFFFFF9; rs2 = 32'd2;
    repeat (5) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    chk("arst_result", {32'h0, result}, 64'd0);
    chk("arst_ready", 64'(ready), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_stall", 64'(stallreq), 64'd0);
    #1 rst = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready || busy) pulses++;
    end
    chk("arst_after", 64'(pulses), 64'd0);
    // wide configuration: XLEN=64, DIV_BITS=2
    w_start = 1'b1; w_op = 3'd5; w_rs1 = 64'd100; w_rs2 = 64'd7;
    n = 0;
    do begin
      @(negedge clk);
      w_start = 1'b0;
      n++;
    end while (!w_ready && n < 100);
    chk("wide_lat", 64'(n), 64'd33);
    chk("wide_res", w_result, 64'd14);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV32M/RV64M multiply–divide unit attached beside the execute stage's single-cycle ALU. It accepts one M-extension operation at a time and computes it over several cycles. While it works, it holds the pipeline through `stallreq_o`, which feeds the existing stall controller in the same way as the ALU's `stallreq`. When finished it returns the result with a one-cycle `ready_o` pulse so the execute stage can drive `wdata_o`. Flushes from a taken branch or jump kill an in-flight operation through `annul_i`.

## Interface
- `XLEN`, 32 — operand and result width. Legal values: 32, 64.
- `MUL_LATENCY`, 2 — cycles spent in state MUL. Legal values: 1–4.
- `DIV_BITS`, 1 — quotient bits retired per divide iteration. Legal values: 1, 2, 4. `XLEN % DIV_BITS` must equal 0.
- `clk`  in  1  — clock; single clock domain.
- `rst`  in  1  — asynchronous, active-high reset.
- `start_i`  in  1  — request. Sampled only in IDLE.
- `op_i`  in  3  — funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `rs1_i`, `rs2_i`  in  XLEN  — operands, latched when start is accepted.
- `annul_i`  in  1  — flush. Aborts the current operation.
- `result_o`  out  XLEN  — result. Valid while `ready_o` is high; holds its value afterwards.
- `ready_o`  out  1  — one-cycle completion pulse.
- `busy_o`  out  1  — state is not IDLE.
- `stallreq_o`  out  1  — pipeline stall request.

## Operation
- States: IDLE, MUL, DIV, DONE.
- **IDLE**
  - `start_i` && !`annul_i` → latch `op_i`, `rs1_i`, `rs2_i`.
  - `op_i[2]`=0 → MUL.
  - `op_i[2]`=1 → DIV, or → DONE directly if a special case applies.
- **MUL**
  - Forms the 2·XLEN-bit product.
  - Operand signedness: MUL and MULH treat both operands as signed. MULHSU treats rs1 as signed and rs2 as unsigned. MULHU treats both as unsigned.
  - MUL returns the low XLEN bits. All other multiply ops return the high XLEN bits.
  - A counter runs 0..`MUL_LATENCY`-1, then the state moves to DONE.
  - Internal pipelining of the product across those cycles is permitted.
- **DIV**
  - Restoring division on magnitudes: the absolute value for DIV/REM, raw operands for DIVU/REMU.
  - Each iteration retires `DIV_BITS` quotient bits. The unit runs `XLEN/DIV_BITS` iterations.
  - Sign fix-up is applied when the result is registered on the transition to DONE:
    - quotient is negated when the operand signs differ;
    - remainder takes the sign of the dividend.
- **Special cases** (decided in IDLE, go straight to DONE):
  - divisor = 0: DIV/DIVU → all ones; REM/REMU → rs1.
  - DIV/REM with rs1 = most-negative value and rs2 = −1: DIV → rs1; REM → 0.
- **DONE**
  - `ready_o`=1 for this cycle, and `result_o` is valid.
  - Next state is always IDLE.
- **Annul and start rules**
  - `annul_i` in any state → IDLE on the next edge. No `ready_o` pulse is produced. `result_o` keeps its previous value.
  - `annul_i` has priority over `start_i`.
  - `start_i` outside IDLE is ignored. The stage does not re-assert it while `stallreq_o` is high.
- **Outputs**
  - `stallreq_o` = (IDLE && `start_i` && !`annul_i`) || MUL || DIV.
  - `stallreq_o` is low in DONE, so the consuming instruction advances in the cycle `ready_o` is high.
  - `busy_o` = (state != IDLE).

## Timing
- **Reset** is asynchronous. It takes effect immediately, not at the next edge:
  - state = IDLE;
  - `result_o` = 0, `ready_o` = 0, `busy_o` = 0, `stallreq_o` = 0;
  - all counters and operand registers = 0.
- Reset asserted mid-operation discards the operation. No pulse is produced.
- **Latency**, with start accepted in cycle N; `ready_o` is high in cycle:
  - multiply: N + `MUL_LATENCY` + 1.
  - divide/remainder: N + `XLEN/DIV_BITS` + 1.
  - special-case divide: N + 1.
- `stallreq_o` is high from cycle N (combinational on `start_i`) through the cycle before `ready_o`.
- **Back-to-back operations:** a new start may be presented in the cycle after DONE, which is IDLE. Minimum issue interval = latency + 1.
- **Registered vs combinational outputs:** `result_o` and `ready_o` are registered. `stallreq_o` is combinational from state and `start_i`.

## Test plan
All scenarios use defaults (XLEN=32, `MUL_LATENCY`=2, `DIV_BITS`=1) unless stated.
- **Multiply:**
  - MUL 7 × 0xFFFFFFFD → `result_o` 0xFFFFFFEB, with `ready_o` pulse at N+3.
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- **Signed divide:**
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD.
  - REM of the same operands → 0xFFFFFFFF.
  - `ready_o` at N+33; `stallreq_o` high N..N+32.
- **Special cases:**
  - DIVU 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
  - Each pulses at N+1.
- **Flush:**
  - `annul_i` in cycle N+10 of a DIV → no `ready_o`, and `busy_o`/`stallreq_o` low from N+11.
  - `result_o` unchanged.
  - A new MUL started at N+11 completes at N+14.
- **Start while busy:** `start_i` toggled while in MUL or DIV → ignored, and the in-flight result is unchanged.
- **Asynchronous reset:**
  - `rst` pulsed mid-DIV between clock edges → all outputs 0 before the next edge, and no pulse afterwards.
- **Wide configuration:** XLEN=64, `DIV_BITS`=2, DIVU 100/7 → 14 with `ready_o` at N+33.
